ddio_in_deser: RTL and testbench
================================

# ddio_in_deser

Parametrised DDR input deserializer that sits directly behind the per-pin DDIO input capture atoms. It takes the rising-edge and falling-edge sample buses, one pair per enabled clock. For each lane it assembles the resulting bit stream into 2·RATIO-bit words. Word-boundary alignment is done with a bitslip control, and each completed word is flagged with a valid pulse. It generalises single-pin DDIO capture to WIDTH lanes, a programmable gearbox ratio and runtime alignment.

## Interface
- WIDTH, 8: number of lanes (1..32).
- RATIO, 2: enabled clocks per output word (1..8). Each lane word is 2·RATIO bits.
- POWER_UP, "low": reset/power-up value of data registers, either "low" (all 0) or "high" (all 1).

Ports:
- clk  in  1  capture clock; all state on rising edge.
- areset  in  1  asynchronous, active-high reset.
- clkena  in  1  clock enable. When low, all state holds and bitslip is ignored.
- datain_h  in  WIDTH  rising-edge samples; bit i is lane i, earlier in time.
- datain_l  in  WIDTH  falling-edge samples; bit i is lane i, later in time.
- bitslip  in  1  level-sampled slip request.
- dataout  out  WIDTH·2·RATIO  lane i at [i·2R +: 2R]; earliest bit at the lane MSB.
- dataout_valid  out  1  one-cycle pulse when dataout updates.
- slip_busy  out  1  high from an accepted slip until the next word is emitted.
- slip_offset  out  clog2(2R), min 1  current bit offset, 0..2R−1.

## Operation
- Stream per lane:
  - On enabled edge k, bits s[2k] = datain_h[i] and s[2k+1] = datain_l[i] are appended.
  - k counts enabled edges since reset.
- Storage: per-lane shift history of 4·RATIO bits, shifted by 2 per enabled edge.
- Phase counter: 0..R−1, incremented per enabled edge, wraps R−1→0. One group completes each time it wraps.
- Word emission (offset o = slip_offset):
  - On the enabled edge completing group n+1 (n ≥ 0), word n = s[2Rn+o .. 2Rn+o+2R−1] is loaded into dataout and dataout_valid is high for the following cycle.
  - No word is emitted on completion of group 0 (priming). A primed flag tracks this.
  - dataout holds its value between emissions.
- Bitslip:
  - Accepted on an edge with clkena=1, bitslip=1 and slip_busy=0.
  - On acceptance: slip_offset ← (slip_offset+1) mod 2R, wrapping 2R−1→0, and slip_busy←1.
  - Requests while busy or with clkena=0 are dropped, not queued.
  - slip_busy clears on the next emission edge. That emitted word already uses the new offset.
- Simultaneous events:
  - A slip accepted on an emission edge does not affect the word emitted on that edge.
  - slip_busy stays 1 after that edge and clears at the following emission.
- Wrap to offset 0 does not re-prime and does not drop or duplicate a word. The stream position is continuous modulo 2R.

## Timing
- Reset (areset=1, asynchronous, any time):
  - dataout = POWER_UP fill, history = POWER_UP fill.
  - dataout_valid = 0, slip_busy = 0, slip_offset = 0, phase = 0, primed = 0.
- Deassertion is sampled on clk. The first enabled edge afterwards captures s[0..1].
- First dataout_valid follows the 2R-th enabled edge after reset.
- Afterwards, one valid pulse per R enabled edges. With clkena=1 continuously, valid occurs every R cycles.
- For RATIO=1, valid is continuous (every cycle) after priming.
- clkena=0 stretches timing. dataout_valid deasserts on the next cycle regardless of clkena; the pulse is never stretched.
- Latency: bit s[j] appears in dataout at most 2R enabled edges after its capture edge.
- Reset mid-word discards partial groups and re-primes.

## Test plan
- Reset values:
  - areset pulse mid-stream with POWER_UP="high", WIDTH=2, RATIO=2 → dataout=8'hFF, valid=0, slip_offset=0, slip_busy=0 asynchronously, before any clk edge.
- Basic gearbox, WIDTH=1, RATIO=2, clkena=1:
  - Stimulus (h,l) = (1,0),(1,1),(0,0),(1,0).
  - → valid after the 4th edge, dataout=4'b1011.
  - Continue with (1,1),(0,1) → next valid after the 6th edge, dataout=4'b0010.
- Bitslip:
  - Same stream, with bitslip=1 on edge 2 → slip_offset=1, slip_busy=1.
  - First word = s1..s4 = 4'b0110, and slip_busy clears on that same edge.
  - A second bitslip on edge 3, while busy, is ignored: offset stays 1.
- Offset wrap, RATIO=2:
  - Four accepted slips, each after a valid → slip_offset 1,2,3,0.
  - Valid count is unchanged versus the no-slip run.
- clkena gaps:
  - Alternate clkena 1/0 with the test-2 stream → identical dataout values.
  - Valid pulses spaced 2× further apart, each exactly one cycle wide.
  - bitslip asserted only while clkena=0 → no offset change.
- Multi-lane and mid-run reset, WIDTH=4, RATIO=3:
  - Lanes driven with distinct patterns → each 6-bit field matches its lane stream.
  - areset during phase 1 → next valid only after 6 further enabled edges.

Source files
------------

// File: rtl/ddio_in_deser.sv
// DDR input deserializer: assembles per-lane rise/fall sample pairs into
// 2*RATIO-bit words, with runtime bitslip alignment and a valid pulse per word.
module ddio_in_deser #(
  parameter int    WIDTH    = 8,
  parameter int    RATIO    = 2,
  parameter string POWER_UP = "low"
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         clkena,
  input  logic [WIDTH-1:0]             datain_h,
  input  logic [WIDTH-1:0]             datain_l,
  input  logic                         bitslip,
  output logic [WIDTH*2*RATIO-1:0]     dataout,
  output logic                         dataout_valid,
  output logic                         slip_busy,
  output logic [$clog2(2*RATIO)-1:0]   slip_offset
);

  localparam int   WB   = 2 * RATIO;
  localparam int   HB   = 4 * RATIO;
  localparam int   OW   = $clog2(WB);
  localparam int   PW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic FILL = (POWER_UP == "high") ? 1'b1 : 1'b0;

  logic [HB-1:0]       hist     [WIDTH];
  logic [HB-1:0]       hist_nxt [WIDTH];
  logic [HB-1:0]       aligned  [WIDTH];
  logic [WIDTH*WB-1:0] word;
  logic [PW-1:0]       phase;
  logic                primed;
  logic                wrap;
  logic                emit;
  logic                accept;

  assign wrap   = (phase == PW'(RATIO - 1));
  assign emit   = clkena & wrap & primed;
  assign accept = clkena & bitslip & ~slip_busy;

  // Word is taken from the history including this edge's samples; the oldest
  // bit sits at the MSB, so the offset shifts the window towards newer bits.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      hist_nxt[i] = {hist[i][HB-3:0], datain_h[i], datain_l[i]};
      aligned[i]  = hist_nxt[i] << slip_offset;
      word[i*WB +: WB] = aligned[i][HB-1 -: WB];
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < WIDTH; i++) hist[i] <= {HB{FILL}};
      dataout       <= {(WIDTH*WB){FILL}};
      dataout_valid <= 1'b0;
      slip_busy     <= 1'b0;
      slip_offset   <= '0;
      phase         <= '0;
      primed        <= 1'b0;
    end else begin
      dataout_valid <= emit;
      if (clkena) begin
        for (int unsigned i = 0; i < WIDTH; i++) hist[i] <= hist_nxt[i];
        phase <= wrap ? '0 : phase + 1'b1;
        if (wrap) primed <= 1'b1;
        if (emit) dataout <= word;
      end
      // A slip accepted on an emission edge keeps busy set until the next word.
      if (accept) begin
        slip_busy   <= 1'b1;
        slip_offset <= (slip_offset == OW'(WB - 1)) ? '0 : slip_offset + 1'b1;
      end else if (emit) begin
        slip_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddio_in_deser.sv
// Scoreboard bench for ddio_in_deser: three configurations, expected words queued
// at stimulus time and popped by per-instance monitors on each valid pulse.
module tb_ddio_in_deser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // A: WIDTH=2, RATIO=2, POWER_UP high; lane 1 carries the inverse of lane 0
  logic       rst_a, ena_a, slip_a, val_a, busy_a;
  logic [1:0] h_a, l_a, off_a;
  logic [7:0] out_a;
  ddio_in_deser #(.WIDTH(2), .RATIO(2), .POWER_UP("high")) dut_a (
    .clk(clk), .areset(rst_a), .clkena(ena_a), .datain_h(h_a), .datain_l(l_a),
    .bitslip(slip_a), .dataout(out_a), .dataout_valid(val_a),
    .slip_busy(busy_a), .slip_offset(off_a));

  // B: WIDTH=4, RATIO=3, POWER_UP low
  logic        rst_b, ena_b, slip_b, val_b, busy_b;
  logic [3:0]  h_b, l_b;
  logic [2:0]  off_b;
  logic [23:0] out_b;
  ddio_in_deser #(.WIDTH(4), .RATIO(3), .POWER_UP("low")) dut_b (
    .clk(clk), .areset(rst_b), .clkena(ena_b), .datain_h(h_b), .datain_l(l_b),
    .bitslip(slip_b), .dataout(out_b), .dataout_valid(val_b),
    .slip_busy(busy_b), .slip_offset(off_b));

  // C: WIDTH=1, RATIO=1
  logic       rst_c, ena_c, slip_c, val_c, busy_c, off_c;
  logic [0:0] h_c, l_c;
  logic [1:0] out_c;
  ddio_in_deser #(.WIDTH(1), .RATIO(1), .POWER_UP("low")) dut_c (
    .clk(clk), .areset(rst_c), .clkena(ena_c), .datain_h(h_c), .datain_l(l_c),
    .bitslip(slip_c), .dataout(out_c), .dataout_valid(val_c),
    .slip_busy(busy_c), .slip_offset(off_c));

  logic [7:0]  q_a[$];
  logic [23:0] q_b[$];
  logic [1:0]  q_c[$];
  int          vt_a[$];
  logic        prev_val_a = 1'b0;

  always @(negedge clk) begin
    if (val_a) begin
      vt_a.push_back(cyc);
      if (q_a.size() == 0) chk("a_unexpected_valid", 32'(out_a), 32'hDEAD);
      else chk("a_word", 32'(out_a), 32'(q_a.pop_front()));
      chk("a_pulse_width", 32'(prev_val_a), 32'd0);
    end
    prev_val_a = val_a;
  end

  always @(negedge clk) begin
    if (val_b) begin
      if (q_b.size() == 0) chk("b_unexpected_valid", 32'(out_b), 32'hDEAD);
      else chk("b_word", 32'(out_b), 32'(q_b.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (val_c) begin
      if (q_c.size() == 0) chk("c_unexpected_valid", 32'(out_c), 32'hDEAD);
      else chk("c_word", 32'(out_c), 32'(q_c.pop_front()));
    end
  end

  logic [1:0]  st2 [6] = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01};
  logic [23:0] pat4    = 24'b1011_0010_1101_0100_0110_1001;
  logic [23:0] pb  [4] = '{24'hA5C396, 24'h3C5A0F, 24'hF0E1D2, 24'h1248F7};
  logic [9:0]  pc      = 10'b11_01_00_10_01;
  int          oa  [5] = '{0, 1, 2, 3, 0};

  function automatic logic [7:0] wa(input logic [3:0] w);
    return {~w, w};
  endfunction

  function automatic logic [3:0] get4(input int start);
    logic [3:0] w;
    for (int b = 0; b < 4; b++) w[3-b] = pat4[23-(start+b)];
    return w;
  endfunction

  function automatic logic [23:0] wb(input int start);
    logic [23:0] w;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 6; b++) w[i*6 + 5 - b] = pb[i][23-(start+b)];
    return w;
  endfunction

  task automatic ea(input logic h, input logic l, input logic en = 1'b1, input logic sl = 1'b0);
    h_a = {~h, h}; l_a = {~l, l}; ena_a = en; slip_a = sl;
    @(posedge clk); #1;
  endtask

  task automatic eb(input int k);
    for (int i = 0; i < 4; i++) begin
      h_b[i] = pb[i][23-2*k];
      l_b[i] = pb[i][22-2*k];
    end
    ena_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst_a();
    rst_a = 1'b1; #1; rst_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ena_a = 1'b0; ena_b = 1'b0; ena_c = 1'b0;
    slip_a = 1'b0; slip_b = 1'b0; slip_c = 1'b0;
    h_a = '0; l_a = '0; h_b = '0; l_b = '0; h_c = '0; l_c = '0;
    #12;
    chk("a_reset_dataout", 32'(out_a), 32'hFF);
    chk("a_reset_valid",   32'(val_a), 32'd0);
    chk("b_reset_dataout", 32'(out_b), 32'd0);
    chk("c_reset_dataout", 32'(out_c), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // basic gearbox
    q_a.push_back(wa(4'b1011));
    q_a.push_back(wa(4'b0010));
    for (int k = 0; k < 6; k++) ea(st2[k][1], st2[k][0]);
    ea(1'b0, 1'b0, 1'b0);
    chk("a_valid_drop", 32'(val_a), 32'd0);
    chk("a_basic_drained", 32'(q_a.size()), 32'd0);

    // asynchronous reset mid-stream, checked before any clock edge
    #1; rst_a = 1'b1; #1;
    chk("a_async_dataout", 32'(out_a), 32'hFF);
    chk("a_async_valid",   32'(val_a), 32'd0);
    chk("a_async_offset",  32'(off_a), 32'd0);
    chk("a_async_busy",    32'(busy_a), 32'd0);
    rst_a = 1'b0;

    // bitslip, then an ignored slip while busy
    q_a.push_back(wa(4'b0110));
    q_a.push_back(wa(4'b0101));
    ea(1'b1, 1'b0);
    ea(1'b1, 1'b1, 1'b1, 1'b1);
    chk("a_slip_offset", 32'(off_a), 32'd1);
    chk("a_slip_busy",   32'(busy_a), 32'd1);
    ea(1'b0, 1'b0, 1'b1, 1'b1);
    chk("a_slip_ignored_busy", 32'(off_a), 32'd1);
    ea(1'b1, 1'b0);
    chk("a_busy_cleared", 32'(busy_a), 32'd0);
    ea(1'b1, 1'b1);
    ea(1'b0, 1'b1);
    ea(1'b0, 1'b0, 1'b0);
    chk("a_slip_drained", 32'(q_a.size()), 32'd0);

    // offset wrap across four slips, each after a valid
    pulse_rst_a();
    vt_a.delete();
    for (int k = 1; k <= 12; k++) begin
      logic sl;
      sl = (k >= 5) && (k % 2 == 1);
      if (k >= 4 && k % 2 == 0) q_a.push_back(wa(get4(4*((k-4)/2) + oa[(k-4)/2])));
      ea(pat4[23-2*(k-1)], pat4[22-2*(k-1)], 1'b1, sl);
      if (sl) chk("a_wrap_offset", 32'(off_a), 32'((k - 3) / 2 % 4));
    end
    ea(1'b0, 1'b0, 1'b0);
    chk("a_wrap_valid_count", 32'(vt_a.size()), 32'd5);
    chk("a_wrap_drained", 32'(q_a.size()), 32'd0);

    // clkena gaps with slips requested only while disabled
    pulse_rst_a();
    vt_a.delete();
    q_a.push_back(wa(4'b1011));
    q_a.push_back(wa(4'b0010));
    for (int k = 0; k < 6; k++) begin
      ea(st2[k][1], st2[k][0]);
      ea(~st2[k][1], ~st2[k][0], 1'b0, 1'b1);
    end
    chk("a_gap_offset", 32'(off_a), 32'd0);
    chk("a_gap_busy",   32'(busy_a), 32'd0);
    chk("a_gap_valid_count", 32'(vt_a.size()), 32'd2);
    if (vt_a.size() == 2) chk("a_gap_spacing", 32'(vt_a[1] - vt_a[0]), 32'd4);
    chk("a_gap_drained", 32'(q_a.size()), 32'd0);

    // multi-lane gearbox, then reset during phase 1 and re-prime
    for (int k = 1; k <= 12; k++) begin
      if (k % 3 == 0 && k >= 6) q_b.push_back(wb(6*((k-6)/3)));
      eb(k - 1);
    end
    h_b = '1; l_b = '1;
    @(posedge clk); #1;
    rst_b = 1'b1; #1;
    chk("b_midreset_dataout", 32'(out_b), 32'd0);
    chk("b_midreset_valid",   32'(val_b), 32'd0);
    rst_b = 1'b0;
    q_b.push_back(wb(0));
    for (int k = 1; k <= 6; k++) begin
      eb(k - 1);
      if (k < 6) chk("b_no_early_valid", 32'(val_b), 32'd0);
    end
    ena_b = 1'b0;
    @(posedge clk); #1;
    chk("b_drained", 32'(q_b.size()), 32'd0);

    // RATIO=1: continuous valid after priming
    for (int k = 1; k <= 5; k++) begin
      if (k >= 2) q_c.push_back({pc[9-2*(k-2)], pc[8-2*(k-2)]});
      h_c[0] = pc[9-2*(k-1)]; l_c[0] = pc[8-2*(k-1)]; ena_c = 1'b1;
      @(posedge clk); #1;
      chk("c_valid_level", 32'(val_c), (k >= 2) ? 32'd1 : 32'd0);
    end
    ena_c = 1'b0;
    @(posedge clk); #1;
    chk("c_drained", 32'(q_c.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion within time limit");
    $fatal(1, "timeout");
  end

endmodule
